lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Buffered HD44780 character-LCD controller that sits directly downstream of the load/store unit's LCD peripheral address. A store to the LCD address delivers a command/data word; the block queues it in a small FIFO and plays each entry out to the LCD pins with correct setup, enable-pulse, hold and execution-wait timing. A status word returns to the load path for polling. Software no longer bit-bangs the enable strobe.

## Interface
- `DEPTH`, 4: FIFO entries, 2..15.
- `SETUP_CYC`, 4: cycles RS/DATA are stable before EN rises, ≥1.
- `EN_CYC`, 25: EN high width in cycles, ≥1.
- `HOLD_CYC`, 2: cycles RS/DATA are held after EN falls, ≥1.
- `CMD_WAIT_CYC`, 2500: execution wait for ordinary commands and data.
- `CLR_WAIT_CYC`, 82000: execution wait for clear/home (RS=0, data 0x01..0x03).
- `POWERUP_CYC`, 750000: power-on delay, used only with `LCD_INIT_EN`.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr` in 1: one-cycle store strobe for the LCD address.
- `wdata` in 32: store data.
- `status` out 32: readable status word.
- `lcd_on` out 1: LCD power.
- `lcd_blon` out 1: backlight.
- `lcd_en` out 1: LCD enable strobe.
- `lcd_rs` out 1: register select.
- `lcd_rw` out 1: read/write; tied to 0 (write-only).
- `lcd_data` out 8: LCD data bus.

## Operation
- Write decode when `wr`=1:
  - `wdata[29]`=1 (control write): `lcd_on`←`wdata[31]` and `lcd_blon`←`wdata[30]` on the next edge. If `wdata[28]`=1, sticky overflow is cleared. Nothing is enqueued; FIFO state does not matter.
  - `wdata[29]`=0 (bus write): enqueue {rs=`wdata[9]`, data=`wdata[7:0]`}. All other bits are ignored.
- Enqueue is accepted when the FIFO is not full, or when a pop occurs in the same cycle. Otherwise the write is dropped and overflow is set (sticky).
- FSM states: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
  - IDLE with FIFO non-empty: pop the head, latch it into `lcd_rs`/`lcd_data`, go to SETUP.
  - SETUP lasts `SETUP_CYC` cycles with EN=0. PULSE lasts `EN_CYC` cycles with EN=1. HOLD lasts `HOLD_CYC` cycles with EN=0.
  - WAIT lasts `CLR_WAIT_CYC` if rs=0 and data[7:2]=0 and data≠0; otherwise it lasts `CMD_WAIT_CYC`.
- Timing counter: one down-counter, wide enough for the largest parameter, reloaded on each state entry.
- `lcd_rs`/`lcd_data` hold their last value in IDLE.
- FIFO: circular buffer. Pointers wrap modulo `DEPTH`. Count width is 4 bits.
- `status` bit map (all other bits 0):
  - [0] busy: state≠IDLE or FIFO non-empty.
  - [1] full.
  - [2] overflow.
  - [7:4] count.
  - [31] `lcd_on`.
  - [30] `lcd_blon`.

## Timing
- All outputs are registered.
- Reset (`rst`=0): every output is 0, FIFO is emptied, overflow=0, FSM=IDLE. This takes effect immediately, including mid-PULSE (EN drops asynchronously).
- Write into an empty FIFO with the FSM in IDLE, accepted at edge k:
  - pop at edge k+1; `lcd_rs`/`lcd_data` valid after edge k+1;
  - `lcd_en`=1 after edge k+1+`SETUP_CYC`;
  - `lcd_en`=0 after edge k+1+`SETUP_CYC`+`EN_CYC`;
  - IDLE after edge k+1+`SETUP_CYC`+`EN_CYC`+`HOLD_CYC`+wait.
- Back-to-back entries: the next pop occurs on the first IDLE cycle, so there is one IDLE cycle between transactions.
- `status` reflects the register state at the current edge; a write is visible in `status` one cycle later.

## Configuration
- `LCD_INIT_EN` defined:
  - After reset, the FSM enters INIT.
  - It waits `POWERUP_CYC` cycles.
  - It then issues internally, RS=0, with full SETUP/PULSE/HOLD/WAIT timing: 0x38, 0x0C, 0x01, 0x06.
  - It then sets `lcd_on`=1 and goes to IDLE.
  - Busy=1 throughout INIT. Bus writes are queued but not issued until INIT completes. Control writes apply immediately.
- `LCD_INIT_EN` undefined: the FSM is IDLE after reset, `lcd_on` stays 0 until a control write, and no INIT logic is built.

## Test plan
All scenarios use SETUP=2, EN=3, HOLD=1, CMD_WAIT=5, CLR_WAIT=20, DEPTH=4.
- Data write: `wr` with 0x0000_0241 at edge k → rs=1 and data=0x41 after k+1; EN high for cycles k+3..k+5; busy falls after edge k+12.
- Clear command: write 0x0000_0001 → rs=0, data=0x01; 20-cycle WAIT; busy falls 26 cycles after the pop.
- Overflow: while the FSM is in WAIT, issue 5 consecutive bus writes → the first 4 are accepted; status reads full=1, overflow=1, count=4; exactly 4 further EN pulses follow, in order. A control write of 0x3000_0000 then clears overflow.
- Control write: write 0xE000_0000 → `lcd_on`=1, `lcd_blon`=1 the next cycle; no EN pulse; count unchanged.
- Reset mid-pulse: drive `rst`=0 during PULSE with 2 entries queued → `lcd_en`=0 immediately; after release, status=0 and no further pulses occur.
- `LCD_INIT_EN`, POWERUP=10: release reset → 4 pulses with data 0x38, 0x0C, 0x01, 0x06 at rs=0; then `lcd_on`=1 and busy=0.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// Store-side bus of the LCD peripheral: one-cycle write strobe, write data and polled status word.
interface lcd_ctrl_if;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] status;

  modport master (output wr, output wdata, input status);
  modport slave  (input wr, input wdata, output status);
endinterface

// File: rtl/lcd_ctrl.sv
// Buffered HD44780 controller: queues store writes and plays them out with setup/EN/hold/wait timing.
// Define LCD_INIT_EN to build the power-on init sequence (0x38, 0x0C, 0x01, 0x06).
module lcd_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned POWERUP_CYC  = 750000
) (
  input  logic       clk,
  input  logic       rst,
  lcd_ctrl_if.slave  bus,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned M0   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned M1   = (M0 > HOLD_CYC) ? M0 : HOLD_CYC;
  localparam int unsigned M2   = (M1 > CMD_WAIT_CYC) ? M1 : CMD_WAIT_CYC;
  localparam int unsigned M3   = (M2 > CLR_WAIT_CYC) ? M2 : CLR_WAIT_CYC;
`ifdef LCD_INIT_EN
  localparam int unsigned MaxCyc = (M3 > POWERUP_CYC) ? M3 : POWERUP_CYC;
  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait, StInit} state_e;
`else
  localparam int unsigned MaxCyc = M3;
  localparam int unsigned unused_powerup = POWERUP_CYC;
  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;
`endif
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [3:0]        count_q;
  logic              ovf_q;
  logic [8:0]        mem_q [DEPTH];
`ifdef LCD_INIT_EN
  logic              init_q;
  logic [1:0]        init_idx_q;
`endif

  logic ctrl_wr, bus_wr, full, busy, pop, push, clr_cmd;
  logic unused_wdata;

  always_comb begin
    ctrl_wr = bus.wr & bus.wdata[29];
    bus_wr  = bus.wr & ~bus.wdata[29];
    full    = (count_q == 4'(DEPTH));
    busy    = (state_q != StIdle) || (count_q != 4'd0);
    pop     = (state_q == StIdle) && (count_q != 4'd0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = bus_wr && (!full || pop);
    clr_cmd = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data != 8'd0);
  end

  assign unused_wdata = ^{bus.wdata[27:10], bus.wdata[8]};
  assign lcd_rw       = 1'b0;
  assign bus.status   = {lcd_on, lcd_blon, 22'd0, count_q, 1'b0, ovf_q, full, busy};

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef LCD_INIT_EN
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.wdata[9], bus.wdata[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef LCD_INIT_EN
      state_q    <= StInit;
      cnt_q      <= CntW'(POWERUP_CYC - 1);
      init_q     <= 1'b1;
      init_idx_q <= 2'd0;
`else
      state_q    <= StIdle;
      cnt_q      <= '0;
`endif
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= 4'd0;
      ovf_q      <= 1'b0;
      lcd_on     <= 1'b0;
      lcd_blon   <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'd0;
    end else begin
      if (push) wptr_q <= inc_ptr(wptr_q);
      if (pop)  rptr_q <= inc_ptr(rptr_q);
      count_q <= count_q + 4'(push) - 4'(pop);

      if (bus_wr && !push)              ovf_q <= 1'b1;
      else if (ctrl_wr && bus.wdata[28]) ovf_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (pop) begin
            {lcd_rs, lcd_data} <= mem_q[rptr_q];
            state_q            <= StSetup;
            cnt_q              <= CntW'(SETUP_CYC - 1);
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q <= StPulse;
            lcd_en  <= 1'b1;
            cnt_q   <= CntW'(EN_CYC - 1);
          end else cnt_q <= cnt_q - 1'b1;
        end
        StPulse: begin
          if (cnt_q == '0) begin
            state_q <= StHold;
            lcd_en  <= 1'b0;
            cnt_q   <= CntW'(HOLD_CYC - 1);
          end else cnt_q <= cnt_q - 1'b1;
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q <= StWait;
            cnt_q   <= clr_cmd ? CntW'(CLR_WAIT_CYC - 1) : CntW'(CMD_WAIT_CYC - 1);
          end else cnt_q <= cnt_q - 1'b1;
        end
        StWait: begin
          if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
            if (init_q && init_idx_q != 2'd3) begin
              init_idx_q <= init_idx_q + 2'd1;
              lcd_data   <= init_cmd(init_idx_q + 2'd1);
              state_q    <= StSetup;
              cnt_q      <= CntW'(SETUP_CYC - 1);
            end else begin
              if (init_q) lcd_on <= 1'b1;
              init_q  <= 1'b0;
              state_q <= StIdle;
            end
`else
            state_q <= StIdle;
`endif
          end else cnt_q <= cnt_q - 1'b1;
        end
`ifdef LCD_INIT_EN
        StInit: begin
          if (cnt_q == '0) begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(2'd0);
            state_q  <= StSetup;
            cnt_q    <= CntW'(SETUP_CYC - 1);
          end else cnt_q <= cnt_q - 1'b1;
        end
`endif
        default: state_q <= StIdle;
      endcase

      // Control writes come last so they win over the end-of-init power-on.
      if (ctrl_wr) begin
        lcd_on   <= bus.wdata[31];
        lcd_blon <= bus.wdata[30];
      end
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: vector table, directed corner sequences, random vs. timeline model.
module tb_lcd_ctrl;
  localparam int unsigned S  = 2;
  localparam int unsigned E  = 3;
  localparam int unsigned H  = 1;
  localparam int unsigned CW = 5;
  localparam int unsigned CL = 20;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_if bus ();
  logic       lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .DEPTH(D), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL), .POWERUP_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .lcd_en(lcd_en),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] wdata;
    logic        rs;
    logic [7:0]  data;
    int          idle;
  } vec_t;
  vec_t vecs[8];

  logic [8:0] seen[$];
  logic [8:0] mq[$];
  int         busy_until, last_pop, rise, fall, idle, nr;
  logic [8:0] cur;
  logic       m_on, m_blon, m_ovf, w, prev, fsm_busy, m_busy, m_en;
  logic [31:0] d, m_status;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [31:0] wd);
    bus.wr = 1'b1;
    bus.wdata = wd;
    step();
    bus.wr = 1'b0;
    bus.wdata = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
  endtask

  // Records each EN rising edge's {rs,data} until busy drops, within a cycle bound.
  task automatic collect(input int bound, input string name);
    logic done;
    logic p;
    done = 1'b0;
    seen.delete();
    for (int n = 0; n < bound; n++) begin
      p = lcd_en;
      step();
      if (!p && lcd_en) seen.push_back({lcd_rs, lcd_data});
      if (!bus.status[0]) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic count_rises(input int cycles, output int n);
    logic p;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      p = lcd_en;
      step();
      if (!p && lcd_en) n++;
    end
  endtask

  function automatic int wait_of(input logic [8:0] e);
    return (!e[8] && e[7:2] == 6'd0 && e[7:0] != 8'd0) ? int'(CL) : int'(CW);
  endfunction

  initial begin
    bus.wr = 1'b0;
    bus.wdata = 32'd0;
    #3;
    chk("reset_outputs", 64'({bus.status, lcd_en, lcd_rs, lcd_data, lcd_on, lcd_blon, lcd_rw}),
        64'd0);
    #4 rst = 1'b1;
`ifdef LCD_INIT_EN
    collect(2000, "init_done");
    chk("init_pulses", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      chk("init_cmd0", 64'(seen[0]), 64'h038);
      chk("init_cmd1", 64'(seen[1]), 64'h00C);
      chk("init_cmd2", 64'(seen[2]), 64'h001);
      chk("init_cmd3", 64'(seen[3]), 64'h006);
    end
    chk("init_lcd_on", 64'(lcd_on), 64'd1);
    chk("init_status", 64'(bus.status), 64'h8000_0000);
`else
    vecs[0] = '{32'h0000_0241, 1'b1, 8'h41, 12};
    vecs[1] = '{32'h0000_0001, 1'b0, 8'h01, 27};
    vecs[2] = '{32'h0000_0002, 1'b0, 8'h02, 27};
    vecs[3] = '{32'h0000_0003, 1'b0, 8'h03, 27};
    vecs[4] = '{32'h0000_0004, 1'b0, 8'h04, 12};
    vecs[5] = '{32'h0000_0000, 1'b0, 8'h00, 12};
    vecs[6] = '{32'h0000_0201, 1'b1, 8'h01, 12};
    vecs[7] = '{32'hDFFF_FDFF, 1'b0, 8'hFF, 12};
    step();
    foreach (vecs[i]) begin
      wr_word(vecs[i].wdata);
      chk("vec_queued", 64'(bus.status), 64'h11);
      step();
      chk("vec_latch", 64'({lcd_rs, lcd_data}), 64'({vecs[i].rs, vecs[i].data}));
      chk("vec_popped", 64'(bus.status), 64'h01);
      rise = -1; fall = -1; idle = -1;
      for (int n = 2; n <= 60 && idle < 0; n++) begin
        prev = lcd_en;
        step();
        if (!prev && lcd_en && rise < 0) rise = n;
        if (prev && !lcd_en && fall < 0) fall = n;
        if (!bus.status[0]) idle = n;
      end
      chk("vec_en_rise", 64'(rise), 64'(1 + S));
      chk("vec_en_fall", 64'(fall), 64'(1 + S + E));
      chk("vec_idle", 64'(idle), 64'(vecs[i].idle));
      chk("vec_hold", 64'({lcd_rs, lcd_data}), 64'({vecs[i].rs, vecs[i].data}));
    end

    // Fill during WAIT: 4 accepted, fifth dropped with sticky overflow.
    wr_word(32'h0000_0241);
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 5; i++) wr_word(32'h0000_0210 + 32'(i));
    chk("ovf_status", 64'(bus.status), 64'h47);
    collect(300, "ovf_drain");
    chk("ovf_pulses", 64'(seen.size()), 64'd4);
    if (seen.size() == 4)
      for (int i = 0; i < 4; i++) chk("ovf_order", 64'(seen[i]), 64'(9'h110 + 9'(i)));
    chk("ovf_sticky", 64'(bus.status), 64'h04);
    wr_word(32'h3000_0000);
    chk("ovf_clear", 64'(bus.status), 64'h00);

    wr_word(32'hE000_0000);
    chk("ctrl_pins", 64'({lcd_on, lcd_blon}), 64'b11);
    chk("ctrl_status", 64'(bus.status), 64'hC000_0000);
    count_rises(20, nr);
    chk("ctrl_no_pulse", 64'(nr), 64'd0);

    wr_word(32'h0000_0241);
    wr_word(32'h0000_0242);
    wr_word(32'h0000_0243);
    chk("rst_queued", 64'(bus.status[7:4]), 64'd2);
    step();
    chk("rst_in_pulse", 64'(lcd_en), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_en", 64'(lcd_en), 64'd0);
    chk("rst_async_status", 64'(bus.status), 64'd0);
    #3 rst = 1'b1;
    count_rises(40, nr);
    chk("rst_no_pulse", 64'(nr), 64'd0);
    chk("rst_after", 64'({bus.status, lcd_on, lcd_rs, lcd_data}), 64'd0);

    // Random traffic vs. a timeline model: pop edges and wait lengths computed arithmetically.
    do_reset();
    mq.delete();
    busy_until = -1; last_pop = -1000; cur = 9'd0;
    m_on = 1'b0; m_blon = 1'b0; m_ovf = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      w = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) d = $urandom | 32'h2000_0000;
      else begin
        d = $urandom & 32'hDFFF_FFFF;
        if ($urandom_range(0, 3) == 0) d[7:0] = 8'($urandom_range(0, 3));
      end
      bus.wr = w;
      bus.wdata = d;
      step();
      if (t >= busy_until + 1 && mq.size() > 0) begin
        cur = mq.pop_front();
        last_pop = t;
        busy_until = t + int'(S + E + H) + wait_of(cur);
      end
      if (w && d[29]) begin
        m_on = d[31];
        m_blon = d[30];
        if (d[28]) m_ovf = 1'b0;
      end else if (w) begin
        if (mq.size() < D) mq.push_back({d[9], d[7:0]});
        else m_ovf = 1'b1;
      end
      fsm_busy = (t < busy_until);
      m_busy = fsm_busy || (mq.size() > 0);
      m_en = (t >= last_pop + int'(S)) && (t < last_pop + int'(S + E));
      m_status = {m_on, m_blon, 22'd0, 4'(mq.size()), 1'b0, m_ovf, mq.size() == D, m_busy};
      chk("random", 64'({bus.status, lcd_en, lcd_rs, lcd_data, lcd_on, lcd_blon, lcd_rw}),
          64'({m_status, m_en, cur, m_on, m_blon, 1'b0}));
    end
    bus.wr = 1'b0;
    bus.wdata = 32'd0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
